// File: rtl/gate_exerciser.sv
`default_nettype none
// ============================================================================
// Module      : gate_exerciser
// Description : Clocked stimulus/check sequencer for a two-input gate cell.
//               Drives vectors 00,01,10,11 for HOLD_CYCLES each, samples the
//               gate output at the end of each hold, compares it against
//               EXPECT_TT and reports error count, first failing vector and
//               pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_exerciser #(
    parameter int         HOLD_CYCLES = 5,        // 1..255
    parameter logic [3:0] EXPECT_TT   = 4'b1000   // indexed by {in1,in2}
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
    localparam logic [7:0] c_hold_last = 8'(HOLD_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_vec;
    logic [7:0] r_hold_cnt;
    logic       r_in1;
    logic       r_in2;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err_count;
    logic [1:0] r_fail_vec;

    logic [1:0] w_state_nxt;
    logic [1:0] w_vec_nxt;
    logic [7:0] w_hold_nxt;
    logic       w_in1_nxt;
    logic       w_in2_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_pass_nxt;
    logic [2:0] w_err_nxt;
    logic [1:0] w_fail_nxt;

    logic       w_sample;
    logic       w_mismatch;

    // Last cycle of the current hold; the gate has settled on the held vector.
    assign w_sample   = (r_hold_cnt == c_hold_last);
    assign w_mismatch = (dut_out != EXPECT_TT[r_vec]);

    // State and all outputs are registered so the gate inputs only move on edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_vec       <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_in1       <= 1'b0;
            r_in2       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_vec  <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec       <= w_vec_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_in1       <= w_in1_nxt;
            r_in2       <= w_in2_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_count <= w_err_nxt;
            r_fail_vec  <= w_fail_nxt;
        end
    end

    // Next-state and next-output logic; gate inputs default to 0 outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_hold_nxt  = r_hold_cnt;
        w_in1_nxt   = 1'b0;
        w_in2_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err_count;
        w_fail_nxt  = r_fail_vec;

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_run;
                    w_vec_nxt   = 2'd0;
                    w_hold_nxt  = 8'd0;
                    w_err_nxt   = 3'd0;
                    w_fail_nxt  = 2'd0;
                    w_pass_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end

            c_st_run: begin
                w_busy_nxt = 1'b1;
                w_in1_nxt  = r_vec[1];
                w_in2_nxt  = r_vec[0];
                w_hold_nxt = r_hold_cnt + 8'd1;
                if (w_sample) begin
                    w_hold_nxt = 8'd0;
                    if (w_mismatch) begin
                        w_err_nxt = r_err_count + 3'd1;
                        // Only the first failing vector is recorded.
                        if (r_err_count == 3'd0) begin
                            w_fail_nxt = r_vec;
                        end
                    end
                    if (r_vec == 2'd3) begin
                        w_state_nxt = c_st_done;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_nxt == 3'd0);
                        w_in1_nxt   = 1'b0;
                        w_in2_nxt   = 1'b0;
                    end else begin
                        w_vec_nxt = r_vec + 2'd1;
                        w_in1_nxt = w_vec_nxt[1];
                        w_in2_nxt = w_vec_nxt[0];
                    end
                end
            end

            c_st_done: begin
                // start is deliberately ignored here; the next run needs IDLE.
                w_state_nxt = c_st_idle;
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign in1       = r_in1;
    assign in2       = r_in2;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_exerciser.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_exerciser
// Description : Self-checking bench for gate_exerciser. Instance A checks an
//               AND truth table (HOLD_CYCLES=5) against swappable gate models;
//               instance B checks XOR with HOLD_CYCLES=1 and start held high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_exerciser;

    localparam int c_hold_a = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    int         sel_a = 0;

    logic       in1_a, in2_a, busy_a, done_a, pass_a, dut_out_a;
    logic [2:0] err_count_a;
    logic [1:0] fail_vec_a;
    logic       in1_b, in2_b, busy_b, done_b, pass_b, dut_out_b;
    logic [2:0] err_count_b;
    logic [1:0] fail_vec_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string name;
        int    sel;
        int    exp_err;
        int    exp_fail_vec;
        int    exp_pass;
    } vec_t;

    vec_t tbl[4];

    // Gate models: 0 AND, 1 OR, 2 stuck-at-0, 3 XOR, 4 AND that is wrong on 00 only.
    function automatic logic model(input int sel, input logic a, input logic b);
        case (sel)
            0:       return a & b;
            1:       return a | b;
            2:       return 1'b0;
            3:       return a ^ b;
            4:       return (a | b) ? (a & b) : 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign dut_out_a = model(sel_a, in1_a, in2_a);
    assign dut_out_b = model(3, in1_b, in2_b);

    gate_exerciser #(.HOLD_CYCLES(c_hold_a), .EXPECT_TT(4'b1000)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .in1       (in1_a),
        .in2       (in2_a),
        .dut_out   (dut_out_a),
        .busy      (busy_a),
        .done      (done_a),
        .pass      (pass_a),
        .err_count (err_count_a),
        .fail_vec  (fail_vec_a)
    );

    gate_exerciser #(.HOLD_CYCLES(1), .EXPECT_TT(4'b0110)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .in1       (in1_b),
        .in2       (in2_b),
        .dut_out   (dut_out_b),
        .busy      (busy_b),
        .done      (done_b),
        .pass      (pass_b),
        .err_count (err_count_b),
        .fail_vec  (fail_vec_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One run on instance A: pulse start, then observe a fixed 30-cycle window.
    // Cycle 1 is the first cycle after the edge that accepted start.
    // inj1/inj2 re-assert start at those cycles to probe restart immunity.
    task automatic run_a(input int sel, input int inj1, input int inj2,
                         output int busy_n, output int done_n,
                         output int done_at, output int seq_err);
        sel_a   = sel;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        seq_err = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("err_cleared_at_T1", int'(err_count_a), 0);
        check("busy_at_T1", int'(busy_a), 1);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (busy_a) begin
                busy_n++;
                if ({in1_a, in2_a} != 2'((cyc - 1) / c_hold_a)) seq_err++;
            end else if (in1_a || in2_a) begin
                seq_err++;
            end
            if (done_a) begin
                done_n++;
                done_at = cyc;
            end
            start_a = (cyc == inj1) || (cyc == inj2);
        end
        start_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, done_n, done_at, seq_err;
        int pat_err, runs, pass_err, done_seen;

        tbl[0] = '{"and_ideal",  0, 0, 0, 1};
        tbl[1] = '{"or_model",   1, 2, 1, 0};
        tbl[2] = '{"stuck_zero", 2, 1, 3, 0};
        tbl[3] = '{"and_again",  0, 0, 0, 1};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_a_outputs",
              int'({in1_a, in2_a, busy_a, done_a, pass_a, err_count_a, fail_vec_a}), 0);
        check("reset_b_outputs",
              int'({in1_b, in2_b, busy_b, done_b, pass_b, err_count_b, fail_vec_b}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven full runs on the AND checker
        for (int i = 0; i < 4; i++) begin
            run_a(tbl[i].sel, 0, 0, busy_n, done_n, done_at, seq_err);
            check({tbl[i].name, "_busy_cycles"}, busy_n, 4 * c_hold_a);
            check({tbl[i].name, "_done_pulses"}, done_n, 1);
            check({tbl[i].name, "_done_cycle"}, done_at, 4 * c_hold_a + 1);
            check({tbl[i].name, "_in_sequence_errs"}, seq_err, 0);
            check({tbl[i].name, "_err_count"}, int'(err_count_a), tbl[i].exp_err);
            check({tbl[i].name, "_fail_vec"}, int'(fail_vec_a), tbl[i].exp_fail_vec);
            check({tbl[i].name, "_pass"}, int'(pass_a), tbl[i].exp_pass);
        end

        // start re-pulsed during vector 10 and during DONE: no restart
        run_a(0, 11, 21, busy_n, done_n, done_at, seq_err);
        check("restart_busy_cycles", busy_n, 4 * c_hold_a);
        check("restart_done_pulses", done_n, 1);
        check("restart_done_cycle", done_at, 4 * c_hold_a + 1);
        check("restart_in_sequence_errs", seq_err, 0);
        check("restart_pass", int'(pass_a), 1);

        // Reset in the middle of vector 10 after one logged error
        sel_a = 4;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (11) @(negedge clk);
        check("midrun_vec_is_10", int'({in1_a, in2_a}), 2);
        check("midrun_err_before_reset", int'(err_count_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_async_reset_outputs",
              int'({in1_a, in2_a, busy_a, done_a, pass_a, err_count_a, fail_vec_a}), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) done_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_a || busy_a) done_seen++;
        end
        check("midrun_no_done_and_idle_after_release", done_seen, 0);
        run_a(0, 0, 0, busy_n, done_n, done_at, seq_err);
        check("after_reset_busy_cycles", busy_n, 4 * c_hold_a);
        check("after_reset_err_count", int'(err_count_a), 0);
        check("after_reset_pass", int'(pass_a), 1);

        // XOR checker, HOLD_CYCLES=1, start held high: run repeats every 6 cycles
        pat_err  = 0;
        runs     = 0;
        pass_err = 0;
        @(negedge clk);
        start_b = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            int ph;
            @(negedge clk);
            ph = (cyc - 1) % 6;
            if ({busy_b, done_b} != {ph < 4, ph == 4}) pat_err++;
            if (ph < 4 && {in1_b, in2_b} != 2'(ph)) pat_err++;
            if (ph >= 4 && (in1_b || in2_b)) pat_err++;
            if (done_b) begin
                runs++;
                if (!pass_b || err_count_b != 3'd0) pass_err++;
            end
        end
        start_b = 1'b0;
        check("xor_held_start_pattern_errs", pat_err, 0);
        check("xor_held_start_runs", runs, 5);
        check("xor_held_start_pass_errs", pass_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
